// File: rtl/mon_pkg.sv
// Shared types for the data-memory write monitor: FSM state and the
// trace entry layout captured on every observed write.
package mon_pkg;

   localparam int ADR_W  = 64;
   localparam int DATA_W = 64;
   localparam int WE_W   = 2;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } mon_state_t;

   typedef struct packed {
      logic [WE_W-1:0]   we;
      logic [ADR_W-1:0]  adr;
      logic [DATA_W-1:0] data;
   } trace_entry_t;

endpackage

// File: rtl/trace_ring.sv
// Overwrite-oldest ring of recent writes. When full, a push without a pop
// drops the oldest entry and sets a sticky overflow flag. The head entry is
// presented combinationally (first-word fall-through).
//
// Handshake: head/valid describe the oldest entry; pop while valid=1
// consumes it at the clock edge and the next entry appears in the same
// cycle. Pop while valid=0 is ignored. Push is a one-cycle strobe with no
// back-pressure.
module trace_ring
   import mon_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  trace_entry_t             push_entry,
   input  logic                     pop,
   output logic                     valid,
   output trace_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   trace_entry_t    mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     cnt_q;
   logic            ovf_q;
   logic            full;
   logic            do_pop;

   assign full   = (cnt_q == FULL_CNT);
   assign do_pop = pop && (cnt_q != '0);

   // Storage is intentionally not reset; only pointers and flags are.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointer, occupancy and overflow bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         // A push into a full ring with no pop evicts the oldest entry.
         if (do_pop || (push && full)) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !do_pop && !full) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (!push && do_pop) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (push && !do_pop && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign valid = (cnt_q != '0);
   assign head  = mem[rd_ptr];
   assign count = cnt_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/mem_write_monitor.sv
// Observer for the CPU data-memory write port. Counts cycles while running,
// declares PASS on the first write matching an enabled check slot (lowest
// slot wins), FAIL when the cycle count reaches TIMEOUT, and records every
// write seen while running into a trace ring for debug readout.
module mem_write_monitor
   import mon_pkg::*;
#(
   parameter int NCHK    = 4,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1580
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                memwrite,
   input  logic [63:0]               dataadr,
   input  logic [63:0]               writedata,
   input  logic [NCHK-1:0]           chk_en,
   input  logic [NCHK*64-1:0]        chk_adr,
   input  logic [NCHK*64-1:0]        chk_data,
   output logic [31:0]               cnt,
   output logic                      done,
   output logic                      pass,
   output logic [$clog2(NCHK)-1:0]   pass_id,
   output logic                      timeout,
   input  logic                      trace_rd,
   output logic                      trace_valid,
   output logic [1:0]                trace_we,
   output logic [63:0]               trace_adr,
   output logic [63:0]               trace_data,
   output logic [$clog2(DEPTH):0]    trace_count,
   output logic                      trace_ovf,
   output logic [1:0]                dbg_state
);

   localparam int IDW = $clog2(NCHK);

   mon_state_t      state_q, state_d;
   logic [31:0]     cnt_q, cnt_d, cnt_inc;
   logic [IDW-1:0]  pass_id_q, pass_id_d;
   logic            wr;
   logic            hit;
   logic [IDW-1:0]  hit_id;
   logic            push;
   trace_entry_t    push_entry;
   trace_entry_t    head;

   assign wr      = (memwrite != 2'b00);
   assign cnt_inc = cnt_q + 32'd1;

   // Priority encoder over the check slots; scanning downward leaves the
   // lowest matching slot as the final assignment.
   always_comb begin
      hit    = 1'b0;
      hit_id = '0;
      for (int i = NCHK - 1; i >= 0; i--) begin
         if (wr && chk_en[i] &&
             (dataadr == chk_adr[64*i +: 64]) &&
             (writedata == chk_data[64*i +: 64])) begin
            hit    = 1'b1;
            hit_id = IDW'(i);
         end
      end
   end

   // State, counter and matched-slot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         pass_id_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pass_id_q <= pass_id_d;
      end
   end

   // Next state: a match beats a timeout landing in the same cycle; the
   // counter only advances in RUN so it freezes at the terminal value.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pass_id_d = pass_id_q;
      case (state_q)
         ST_RUN: begin
            cnt_d = cnt_inc;
            if (hit) begin
               state_d   = ST_PASS;
               pass_id_d = hit_id;
            end else if (cnt_inc == 32'(TIMEOUT)) begin
               state_d = ST_FAIL;
            end
         end
         ST_PASS: state_d = ST_PASS;
         ST_FAIL: state_d = ST_FAIL;
         default: state_d = ST_RUN;
      endcase
   end

   // Only writes observed while running are traced.
   assign push            = (state_q == ST_RUN) && wr;
   assign push_entry.we   = memwrite;
   assign push_entry.adr  = dataadr;
   assign push_entry.data = writedata;

   trace_ring #(
      .DEPTH (DEPTH)
   ) u_trace_ring (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (trace_rd),
      .valid      (trace_valid),
      .head       (head),
      .count      (trace_count),
      .ovf        (trace_ovf)
   );

   assign trace_we   = head.we;
   assign trace_adr  = head.adr;
   assign trace_data = head.data;

   assign cnt       = cnt_q;
   assign pass      = (state_q == ST_PASS);
   assign timeout   = (state_q == ST_FAIL);
   assign done      = pass || timeout;
   assign pass_id   = pass_id_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed-plus-random bench for mem_write_monitor. A queue-based reference
// model tracks the expected status and trace contents each cycle.
module tb_mem_write_monitor;
   import mon_pkg::*;

   localparam int NCHK    = 4;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 1580;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         memwrite;
   logic [63:0]        dataadr;
   logic [63:0]        writedata;
   logic [NCHK-1:0]    chk_en;
   logic [NCHK*64-1:0] chk_adr;
   logic [NCHK*64-1:0] chk_data;
   logic [31:0]        cnt;
   logic               done;
   logic               pass;
   logic [1:0]         pass_id;
   logic               timeout;
   logic               trace_rd;
   logic               trace_valid;
   logic [1:0]         trace_we;
   logic [63:0]        trace_adr;
   logic [63:0]        trace_data;
   logic [3:0]         trace_count;
   logic               trace_ovf;
   logic [1:0]         dbg_state;

   mem_write_monitor #(
      .NCHK (NCHK), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk), .reset (reset), .memwrite (memwrite), .dataadr (dataadr),
      .writedata (writedata), .chk_en (chk_en), .chk_adr (chk_adr),
      .chk_data (chk_data), .cnt (cnt), .done (done), .pass (pass),
      .pass_id (pass_id), .timeout (timeout), .trace_rd (trace_rd),
      .trace_valid (trace_valid), .trace_we (trace_we), .trace_adr (trace_adr),
      .trace_data (trace_data), .trace_count (trace_count),
      .trace_ovf (trace_ovf), .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  we;
      logic [63:0] adr;
      logic [63:0] data;
   } ent_t;

   int          checks   = 0;
   int          failures = 0;
   ent_t        m_q[$];
   logic [31:0] m_cnt;
   bit          m_pass, m_fail, m_ovf;
   int          m_id;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Reference model: apply what the DUT sampled at the last edge.
   task automatic model_update();
      bit run;
      bit found;
      if (reset) begin
         m_cnt = 0; m_pass = 0; m_fail = 0; m_id = 0; m_ovf = 0;
         m_q.delete();
      end else begin
         run = !(m_pass || m_fail);
         if (trace_rd && m_q.size() > 0) void'(m_q.pop_front());
         if (run && memwrite != 0) begin
            if (m_q.size() == DEPTH) begin
               void'(m_q.pop_front());
               m_ovf = 1;
            end
            m_q.push_back('{memwrite, dataadr, writedata});
         end
         if (run) begin
            m_cnt = m_cnt + 1;
            found = 0;
            for (int i = 0; i < NCHK; i++) begin
               if (!found && memwrite != 0 && chk_en[i] &&
                   dataadr == chk_adr[64*i +: 64] && writedata == chk_data[64*i +: 64]) begin
                  found = 1;
                  m_id  = i;
               end
            end
            if (found) m_pass = 1;
            else if (m_cnt == TIMEOUT) m_fail = 1;
         end
      end
   endtask

   task automatic check_all();
      mon_state_t exp_st;
      exp_st = m_pass ? ST_PASS : (m_fail ? ST_FAIL : ST_RUN);
      chk("cnt", 64'(cnt), 64'(m_cnt));
      chk("done", 64'(done), 64'(m_pass | m_fail));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("pass_id", 64'(pass_id), 64'(m_id));
      chk("timeout", 64'(timeout), 64'(m_fail));
      chk("state", 64'(dbg_state), 64'(exp_st));
      chk("trace_valid", 64'(trace_valid), 64'(m_q.size() != 0));
      chk("trace_count", 64'(trace_count), 64'(m_q.size()));
      chk("trace_ovf", 64'(trace_ovf), 64'(m_ovf));
      if (m_q.size() > 0) begin
         chk("trace_we", 64'(trace_we), 64'(m_q[0].we));
         chk("trace_adr", trace_adr, m_q[0].adr);
         chk("trace_data", trace_data, m_q[0].data);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_update();
      check_all();
   endtask

   // Random write to an address that no check slot uses, with random pops.
   task automatic rand_write();
      memwrite  = 2'($urandom_range(0, 3));
      dataadr   = 64'(200 + $urandom_range(0, 299));
      writedata = {$urandom, $urandom};
      trace_rd  = ($urandom_range(0, 3) == 0);
      tick();
   endtask

   task automatic direct_write(input logic [1:0] we, input logic [63:0] adr,
                               input logic [63:0] data, input logic rd);
      memwrite  = we;
      dataadr   = adr;
      writedata = data;
      trace_rd  = rd;
      tick();
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      memwrite = 2'b00;
      trace_rd = 1'b0;
      for (int i = 0; i < n; i++) tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; memwrite = 0; dataadr = 0; writedata = 0; trace_rd = 0;
      chk_en = '0; chk_adr = '0; chk_data = '0;

      // Reset state.
      do_reset(2);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_valid", 64'(trace_valid), 64'd0);

      // Slot 0 match on the 50th running cycle.
      chk_en = 4'b0001;
      chk_adr[0 +: 64] = 64'd100; chk_data[0 +: 64] = 64'd7;
      for (int i = 1; i < 50; i++) rand_write();
      direct_write(2'b01, 64'd100, 64'd7, 1'b0);
      chk("t1_pass", 64'(pass), 64'd1);
      chk("t1_id", 64'(pass_id), 64'd0);
      chk("t1_cnt", 64'(cnt), 64'd50);
      for (int i = 0; i < 6; i++) rand_write();
      chk("t1_cnt_frozen", 64'(cnt), 64'd50);

      // Two identical slots: the lower one wins.
      do_reset(1);
      chk_en = 4'b0110;
      chk_adr[64 +: 64] = 64'd80;  chk_data[64 +: 64] = 64'd1;
      chk_adr[128 +: 64] = 64'd80; chk_data[128 +: 64] = 64'd1;
      for (int i = 0; i < 7; i++) rand_write();
      direct_write(2'b11, 64'd80, 64'd1, 1'b0);
      chk("t2_id", 64'(pass_id), 64'd1);

      // One-cycle reset after PASS, then slot 3 match.
      do_reset(1);
      chk("t7_rst_pass", 64'(pass), 64'd0);
      chk("t7_rst_ovf", 64'(trace_ovf), 64'd0);
      chk_en = 4'b1000;
      chk_adr[192 +: 64] = 64'd508; chk_data[192 +: 64] = 64'd7;
      for (int i = 0; i < 5; i++) rand_write();
      direct_write(2'b10, 64'd508, 64'd7, 1'b1);
      chk("t7_id", 64'(pass_id), 64'd3);
      chk("t7_pass", 64'(pass), 64'd1);

      // Timeout with no match.
      do_reset(1);
      chk_en = 4'b0001;
      for (int i = 1; i < TIMEOUT; i++) rand_write();
      chk("t4_pre_to", 64'(timeout), 64'd0);
      rand_write();
      chk("t4_timeout", 64'(timeout), 64'd1);
      chk("t4_cnt", 64'(cnt), 64'(TIMEOUT));
      chk("t4_nopass", 64'(pass), 64'd0);
      for (int i = 0; i < 4; i++) rand_write();
      chk("t4_frozen", 64'(cnt), 64'(TIMEOUT));

      // Match in the same cycle the count reaches TIMEOUT.
      do_reset(1);
      for (int i = 1; i < TIMEOUT; i++) rand_write();
      direct_write(2'b01, 64'd100, 64'd7, 1'b0);
      chk("t5_pass", 64'(pass), 64'd1);
      chk("t5_timeout", 64'(timeout), 64'd0);

      // Overflow: ten writes into an eight-entry ring, then drain.
      do_reset(1);
      chk_en = 4'b0000;
      for (int i = 0; i < 10; i++) direct_write(2'b01, 64'(i), {$urandom, $urandom}, 1'b0);
      memwrite = 2'b00;
      chk("t6_count", 64'(trace_count), 64'd8);
      chk("t6_ovf", 64'(trace_ovf), 64'd1);
      for (int k = 2; k < 10; k++) begin
         chk("t6_pop_adr", trace_adr, 64'(k));
         trace_rd = 1'b1;
         tick();
      end
      trace_rd = 1'b0;
      chk("t6_empty", 64'(trace_valid), 64'd0);
      // Pop while empty is ignored; push still lands.
      direct_write(2'b01, 64'd42, 64'd9, 1'b1);
      chk("t6_push_on_empty", 64'(trace_count), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
